// File: rtl/wf68k30l_pkg.sv
// Shared types and constants for the wf68k30l core.
// Function codes, exception vectors and prefetch queue helpers.
package wf68k30l_pkg;

  localparam logic [2:0] FC_USER_PROG  = 3'b010;
  localparam logic [2:0] FC_SUPER_PROG = 3'b110;
  localparam logic [7:0] VEC_ADDR_ERROR = 8'd3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD,
    HALT
  } pfq_state_t;

  // Circular pointer advance; depth is at most 16 words.
  function automatic logic [4:0] pfq_wrap(
    input logic [4:0] p,
    input logic [2:0] n,
    input logic [4:0] depth
  );
    logic [5:0] s;
    s = {1'b0, p} + 6'(n);
    if (s >= {1'b0, depth}) s = s - {1'b0, depth};
    return s[4:0];
  endfunction

endpackage

// File: rtl/wf68k30l_pfq_ram.sv
// Prefetch queue storage: 16-bit word plus bus-error tag per entry.
// Two write ports for a longword and a three-word read window.
module wf68k30l_pfq_ram
  import wf68k30l_pkg::*;
#(
  parameter int DEPTH_W = 8,
  parameter int AW = $clog2(DEPTH_W)
) (
  input  logic          clk,
  input  logic          we_hi,
  input  logic [AW-1:0] adr_hi,
  input  logic [16:0]   din_hi,
  input  logic          we_lo,
  input  logic [AW-1:0] adr_lo,
  input  logic [16:0]   din_lo,
  input  logic [AW-1:0] rd_ptr,
  output logic [16:0]   rd0,
  output logic [16:0]   rd1,
  output logic [16:0]   rd2
);

  logic [16:0] mem [DEPTH_W];
  logic [AW-1:0] p1, p2;

  always_ff @(posedge clk) begin
    if (we_hi) mem[adr_hi] <= din_hi;
    if (we_lo) mem[adr_lo] <= din_lo;
  end

  always_comb begin
    p1 = AW'(pfq_wrap(5'(rd_ptr), 3'd1, 5'(DEPTH_W)));
    p2 = AW'(pfq_wrap(5'(rd_ptr), 3'd2, 5'(DEPTH_W)));
    rd0 = mem[rd_ptr];
    rd1 = mem[p1];
    rd2 = mem[p2];
  end

endmodule

// File: rtl/wf68k30l_prefetch_queue.sv
// Instruction prefetch queue feeding the opcode decoder.
// Longword fetches are split into tagged words; redirects flush the queue.
module wf68k30l_prefetch_queue
  import wf68k30l_pkg::*;
#(
  parameter int          DEPTH_W  = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH,
  input  logic [31:0] FLUSH_PC,
  input  logic        SBIT,
  output logic        FETCH_REQ,
  output logic [31:0] FETCH_ADR,
  output logic [2:0]  FETCH_FC,
  input  logic        FETCH_ACK,
  input  logic [31:0] FETCH_DATA,
  input  logic        FETCH_BERR,
  output logic [15:0] OPWORD,
  output logic [15:0] EXT_WORD1,
  output logic [15:0] EXT_WORD2,
  output logic [1:0]  WORDS_VALID,
  output logic [2:0]  WORD_BERR,
  output logic        ADR_ERR,
  input  logic [1:0]  CONSUME
);

  localparam int AW = $clog2(DEPTH_W);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(DEPTH_W);

  pfq_state_t    state, state_n;
  logic [31:0]   fetch_adr, fetch_adr_n;
  logic [31:0]   pend_adr, pend_adr_n;
  logic [2:0]    fc, fc_n;
  logic          skip, skip_n;
  logic          adr_err, adr_err_n;
  logic [CW-1:0] count, count_n;
  logic [AW-1:0] rd_ptr, rd_ptr_n;
  logic [AW-1:0] wr_ptr, wr_ptr_n;

  logic [1:0]    wv, pop;
  logic [CW-1:0] after_pop, count_ack, wr_cnt;
  logic          can_fetch;
  logic          we_hi, we_lo;
  logic [AW-1:0] adr_lo;
  logic [16:0]   rd0, rd1, rd2;
  logic [2:0]    fc_new;
  logic [31:0]   flush_adr;

  wf68k30l_pfq_ram #(
    .DEPTH_W(DEPTH_W),
    .AW     (AW)
  ) u_ram (
    .clk   (CLK),
    .we_hi (we_hi),
    .adr_hi(wr_ptr),
    .din_hi({FETCH_BERR, FETCH_DATA[31:16]}),
    .we_lo (we_lo),
    .adr_lo(adr_lo),
    .din_lo({FETCH_BERR, FETCH_DATA[15:0]}),
    .rd_ptr(rd_ptr),
    .rd0   (rd0),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  always_comb begin
    wv = (count >= CW'(3)) ? 2'd3 : count[1:0];
    pop = (CONSUME > wv) ? wv : CONSUME;
    after_pop = count - CW'(pop);
    wr_cnt = skip ? CW'(1) : CW'(2);
    count_ack = after_pop + wr_cnt;
    can_fetch = (DEPTH - after_pop) >= wr_cnt;
    fc_new = SBIT ? FC_SUPER_PROG : FC_USER_PROG;
    flush_adr = {FLUSH_PC[31:2], 2'b00};
    adr_lo = skip ? wr_ptr
                  : AW'(pfq_wrap(5'(wr_ptr), 3'd1, 5'(DEPTH_W)));
  end

  always_comb begin
    state_n = state;
    fetch_adr_n = fetch_adr;
    pend_adr_n = pend_adr;
    fc_n = fc;
    skip_n = skip;
    adr_err_n = adr_err;
    count_n = after_pop;
    rd_ptr_n = AW'(pfq_wrap(5'(rd_ptr), 3'(pop), 5'(DEPTH_W)));
    wr_ptr_n = wr_ptr;
    we_hi = 1'b0;
    we_lo = 1'b0;
    unique case (state)
      IDLE: begin
        if (can_fetch) begin
          state_n = REQ;
          fc_n = fc_new;
        end
      end
      REQ: begin
        if (FETCH_ACK) begin
          we_hi = !skip;
          we_lo = 1'b1;
          count_n = count_ack;
          wr_ptr_n = AW'(pfq_wrap(5'(wr_ptr), 3'(wr_cnt),
                                  5'(DEPTH_W)));
          fetch_adr_n = fetch_adr + 32'd4;
          skip_n = 1'b0;
          if (FETCH_BERR) begin
            state_n = HALT;
          end else if ((DEPTH - count_ack) >= CW'(2)) begin
            state_n = REQ;
            fc_n = fc_new;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DISCARD: begin
        if (FETCH_ACK) begin
          fetch_adr_n = pend_adr;
          state_n = adr_err ? HALT : REQ;
          fc_n = fc_new;
        end
      end
      HALT: begin
        state_n = HALT;
      end
    endcase
    // Redirect wins over pops and returning fetch data.
    if (FLUSH) begin
      we_hi = 1'b0;
      we_lo = 1'b0;
      count_n = '0;
      rd_ptr_n = '0;
      wr_ptr_n = '0;
      skip_n = FLUSH_PC[1];
      adr_err_n = FLUSH_PC[0];
      if ((state == REQ || state == DISCARD) && !FETCH_ACK) begin
        fetch_adr_n = fetch_adr;
        pend_adr_n = flush_adr;
        state_n = DISCARD;
      end else begin
        fetch_adr_n = flush_adr;
        state_n = FLUSH_PC[0] ? HALT : REQ;
        fc_n = fc_new;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      fetch_adr <= {RESET_PC[31:2], 2'b00};
      pend_adr <= {RESET_PC[31:2], 2'b00};
      fc <= FC_SUPER_PROG;
      skip <= RESET_PC[1];
      adr_err <= 1'b0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_n;
      fetch_adr <= fetch_adr_n;
      pend_adr <= pend_adr_n;
      fc <= fc_n;
      skip <= skip_n;
      adr_err <= adr_err_n;
      count <= count_n;
      rd_ptr <= rd_ptr_n;
      wr_ptr <= wr_ptr_n;
    end
  end

  always_comb begin
    FETCH_REQ = (state == REQ) || (state == DISCARD);
    FETCH_ADR = fetch_adr;
    FETCH_FC = fc;
    ADR_ERR = adr_err;
    WORDS_VALID = wv;
    OPWORD = (wv >= 2'd1) ? rd0[15:0] : 16'h0000;
    EXT_WORD1 = (wv >= 2'd2) ? rd1[15:0] : 16'h0000;
    EXT_WORD2 = (wv == 2'd3) ? rd2[15:0] : 16'h0000;
    WORD_BERR = {(wv == 2'd3) && rd2[16],
                 (wv >= 2'd2) && rd1[16],
                 (wv >= 2'd1) && rd0[16]};
  end

  // Decoder must never pop more than it was shown.
  assert property (@(posedge CLK) disable iff (RESET)
    CONSUME <= wv);

endmodule

// File: tb/tb_wf68k30l_prefetch_queue.sv
// Directed bench for the prefetch queue.
// Inputs change and outputs are sampled on the falling edge.
module tb_wf68k30l_prefetch_queue;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        FLUSH;
  logic [31:0] FLUSH_PC;
  logic        SBIT;
  logic        FETCH_REQ;
  logic [31:0] FETCH_ADR;
  logic [2:0]  FETCH_FC;
  logic        FETCH_ACK;
  logic [31:0] FETCH_DATA;
  logic        FETCH_BERR;
  logic [15:0] OPWORD, EXT_WORD1, EXT_WORD2;
  logic [1:0]  WORDS_VALID;
  logic [2:0]  WORD_BERR;
  logic        ADR_ERR;
  logic [1:0]  CONSUME;

  int n_chk = 0;
  int n_pass = 0;

  wf68k30l_prefetch_queue #(
    .DEPTH_W (8),
    .RESET_PC(32'h100)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .FLUSH      (FLUSH),
    .FLUSH_PC   (FLUSH_PC),
    .SBIT       (SBIT),
    .FETCH_REQ  (FETCH_REQ),
    .FETCH_ADR  (FETCH_ADR),
    .FETCH_FC   (FETCH_FC),
    .FETCH_ACK  (FETCH_ACK),
    .FETCH_DATA (FETCH_DATA),
    .FETCH_BERR (FETCH_BERR),
    .OPWORD     (OPWORD),
    .EXT_WORD1  (EXT_WORD1),
    .EXT_WORD2  (EXT_WORD2),
    .WORDS_VALID(WORDS_VALID),
    .WORD_BERR  (WORD_BERR),
    .ADR_ERR    (ADR_ERR),
    .CONSUME    (CONSUME)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic ack(input logic [31:0] data, input logic berr);
    int i;
    for (i = 0; i < 20 && !FETCH_REQ; i++) tick();
    chk("req_before_ack", 32'(FETCH_REQ), 32'd1);
    FETCH_ACK = 1'b1;
    FETCH_DATA = data;
    FETCH_BERR = berr;
    tick();
    FETCH_ACK = 1'b0;
    FETCH_BERR = 1'b0;
  endtask

  task automatic win(input string tag, input logic [1:0] v,
                     input logic [15:0] w0, input logic [15:0] w1,
                     input logic [15:0] w2);
    chk({tag, "_wv"}, 32'(WORDS_VALID), 32'(v));
    chk({tag, "_op"}, 32'(OPWORD), 32'(w0));
    chk({tag, "_e1"}, 32'(EXT_WORD1), 32'(w1));
    chk({tag, "_e2"}, 32'(EXT_WORD2), 32'(w2));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    FLUSH = 1'b0;
    FLUSH_PC = '0;
    SBIT = 1'b1;
    FETCH_ACK = 1'b0;
    FETCH_DATA = '0;
    FETCH_BERR = 1'b0;
    CONSUME = 2'd0;
    tick();
    tick();
    chk("rst_req", 32'(FETCH_REQ), 32'd0);
    chk("rst_adr", FETCH_ADR, 32'h100);
    chk("rst_fc", 32'(FETCH_FC), 32'h6);
    chk("rst_wv", 32'(WORDS_VALID), 32'd0);
    chk("rst_berr", 32'(WORD_BERR), 32'd0);
    chk("rst_aerr", 32'(ADR_ERR), 32'd0);
    RESET = 1'b0;
    tick();
    chk("t1_req", 32'(FETCH_REQ), 32'd1);
    chk("t1_adr", FETCH_ADR, 32'h100);
    chk("t1_fc", 32'(FETCH_FC), 32'h6);
    ack(32'h1111_2222, 1'b0);
    win("t1a", 2'd2, 16'h1111, 16'h2222, 16'h0000);
    chk("t1_adr2", FETCH_ADR, 32'h104);
    ack(32'h3333_4444, 1'b0);
    win("t1b", 2'd3, 16'h1111, 16'h2222, 16'h3333);

    // redirect while the fetch at 0x108 is in flight
    chk("t3_adr", FETCH_ADR, 32'h108);
    FLUSH = 1'b1;
    FLUSH_PC = 32'h300;
    tick();
    FLUSH = 1'b0;
    chk("t3_req", 32'(FETCH_REQ), 32'd1);
    chk("t3_hold", FETCH_ADR, 32'h108);
    chk("t3_wv", 32'(WORDS_VALID), 32'd0);
    ack(32'hDEAD_BEEF, 1'b0);
    chk("t3_drop", 32'(WORDS_VALID), 32'd0);
    chk("t3_new", FETCH_ADR, 32'h300);
    chk("t3_req2", 32'(FETCH_REQ), 32'd1);
    ack(32'h5555_6666, 1'b0);
    win("t3", 2'd2, 16'h5555, 16'h6666, 16'h0000);

    // misaligned redirect, coincident with an ack that is ignored
    FETCH_ACK = 1'b1;
    FETCH_DATA = 32'h7777_8888;
    FLUSH = 1'b1;
    FLUSH_PC = 32'h202;
    SBIT = 1'b0;
    tick();
    FETCH_ACK = 1'b0;
    FLUSH = 1'b0;
    chk("t2_adr", FETCH_ADR, 32'h200);
    chk("t2_fc", 32'(FETCH_FC), 32'h2);
    chk("t2_wv", 32'(WORDS_VALID), 32'd0);
    ack(32'hAAAA_BBBB, 1'b0);
    win("t2", 2'd1, 16'hBBBB, 16'h0000, 16'h0000);
    chk("t2_adr2", FETCH_ADR, 32'h204);

    // bus error
    ack(32'hCCCC_DDDD, 1'b1);
    win("t4", 2'd3, 16'hBBBB, 16'hCCCC, 16'hDDDD);
    chk("t4_tag", 32'(WORD_BERR), 32'h6);
    chk("t4_req", 32'(FETCH_REQ), 32'd0);
    repeat (4) tick();
    chk("t4_halt", 32'(FETCH_REQ), 32'd0);
    CONSUME = 2'd1;
    tick();
    CONSUME = 2'd0;
    win("t4c", 2'd2, 16'hCCCC, 16'hDDDD, 16'h0000);
    chk("t4_tag2", 32'(WORD_BERR), 32'h3);
    SBIT = 1'b1;
    FLUSH = 1'b1;
    FLUSH_PC = 32'h400;
    tick();
    FLUSH = 1'b0;
    chk("t4_req2", 32'(FETCH_REQ), 32'd1);
    chk("t4_adr", FETCH_ADR, 32'h400);
    chk("t4_fc", 32'(FETCH_FC), 32'h6);
    chk("t4_wv", 32'(WORDS_VALID), 32'd0);
    chk("t4_tag3", 32'(WORD_BERR), 32'd0);

    // odd redirect
    FETCH_ACK = 1'b1;
    FETCH_DATA = 32'h1234_5678;
    FLUSH = 1'b1;
    FLUSH_PC = 32'h401;
    tick();
    FETCH_ACK = 1'b0;
    FLUSH = 1'b0;
    chk("t5_aerr", 32'(ADR_ERR), 32'd1);
    chk("t5_req", 32'(FETCH_REQ), 32'd0);
    chk("t5_wv", 32'(WORDS_VALID), 32'd0);
    repeat (3) tick();
    chk("t5_aerr2", 32'(ADR_ERR), 32'd1);
    chk("t5_req2", 32'(FETCH_REQ), 32'd0);
    FLUSH = 1'b1;
    FLUSH_PC = 32'h500;
    tick();
    FLUSH = 1'b0;
    chk("t5_aerr3", 32'(ADR_ERR), 32'd0);
    chk("t5_req3", 32'(FETCH_REQ), 32'd1);
    chk("t5_adr", FETCH_ADR, 32'h500);

    // fill to depth, then pop while fetching
    ack(32'h0001_0002, 1'b0);
    ack(32'h0003_0004, 1'b0);
    ack(32'h0005_0006, 1'b0);
    ack(32'h0007_0008, 1'b0);
    chk("t6_full", 32'(FETCH_REQ), 32'd0);
    chk("t6_adr", FETCH_ADR, 32'h510);
    win("t6a", 2'd3, 16'h0001, 16'h0002, 16'h0003);
    repeat (2) tick();
    chk("t6_full2", 32'(FETCH_REQ), 32'd0);
    CONSUME = 2'd3;
    tick();
    CONSUME = 2'd0;
    chk("t6_req", 32'(FETCH_REQ), 32'd1);
    win("t6b", 2'd3, 16'h0004, 16'h0005, 16'h0006);
    CONSUME = 2'd3;
    ack(32'h0009_000A, 1'b0);
    CONSUME = 2'd0;
    win("t6c", 2'd3, 16'h0007, 16'h0008, 16'h0009);
    chk("t6_req2", 32'(FETCH_REQ), 32'd1);
    chk("t6_adr2", FETCH_ADR, 32'h514);
    CONSUME = 2'd3;
    tick();
    CONSUME = 2'd0;
    win("t6d", 2'd1, 16'h000A, 16'h0000, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
